// File: rtl/dsp_mac_wb.sv
// dsp_mac_wb: Wishbone-attached multiply-accumulate engine.
// Holds CHANNELS signed operand pairs (A_c, B_c) and accumulators (ACC_c).
// When started, it feeds every channel in turn through one shared two-stage
// multiplier. The mode can be multiply, multiply-accumulate or
// multiply-subtract, and the result can optionally saturate.
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   wb_CYC/STB/WE/SEL/ADR/DAT_MOSI  Wishbone classic slave inputs
//   wb_ACK, wb_DAT_MISO         single-cycle acknowledge, registered read data
//   irq_o                       completion level (STATUS.DONE)
//   dac_o                       top DW bits of ACC[DSEL], latched at run end
//   busy_o                      run in progress
module dsp_mac_wb #(
   parameter int CHANNELS = 4,
   parameter int DW       = 16,
   parameter int ACCW     = 40
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n_i,
   input  logic          wb_CYC,
   input  logic          wb_STB,
   input  logic          wb_WE,
   input  logic [3:0]    wb_SEL,
   input  logic [31:0]   wb_ADR,
   input  logic [31:0]   wb_DAT_MOSI,
   output logic          wb_ACK,
   output logic [31:0]   wb_DAT_MISO,
   output logic          irq_o,
   output logic [DW-1:0] dac_o,
   output logic          busy_o
);

   // Storage is sized for the maximum channel count so a 3-bit channel index
   // always fits. Entries at or above CHANNELS are never written.
   localparam int NCH = 8;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                  state_q;
   logic [2:0]              idx_q;
   logic                    dcnt_q;
   logic                    busy_q, done_q;
   logic [DW-1:0]           dac_q;
   logic [1:0]              mode_q;
   logic                    sat_q;
   logic [2:0]              dsel_q;
   logic [NCH-1:0]          ovf_q;
   logic signed [DW-1:0]    a_q   [NCH];
   logic signed [DW-1:0]    b_q   [NCH];
   logic signed [ACCW-1:0]  acc_q [NCH];
   logic                    ack_q;
   logic [31:0]             rdat_q;

   logic                    vld_p1;
   logic [2:0]              ch_p1;
   logic signed [2*DW-1:0]  prod_p1;

   // ---------------- bus decode ----------------
   logic        req, wr;
   logic [5:0]  w, ab_off;
   logic        ab_hit, ab_isb, acc_hit, acc_hi;
   logic [2:0]  ab_ch, acc_ch;
   logic [31:0] rd_d;
   logic signed [63:0] acc_ext;
   logic        unused_bits;

   assign req     = wb_CYC & wb_STB & ~ack_q;
   assign wr      = req & wb_WE & (wb_SEL == 4'hF);
   assign w       = wb_ADR[7:2];
   assign ab_off  = w - 6'd4;
   assign ab_ch   = ab_off[3:1];
   assign ab_isb  = ab_off[0];
   assign ab_hit  = (w >= 6'd4) && (w < 6'd20) && ({1'b0, ab_ch} < 4'(CHANNELS));
   assign acc_ch  = w[3:1];
   assign acc_hi  = w[0];
   assign acc_hit = (w[5:4] == 2'b10) && ({1'b0, acc_ch} < 4'(CHANNELS));
   assign unused_bits = ^{wb_ADR[31:8], wb_ADR[1:0], wb_DAT_MOSI};

   always_comb begin
      rd_d    = '0;
      acc_ext = 64'(acc_q[acc_ch]);
      if (w == 6'd0)
         rd_d = {21'd0, dsel_q, 3'd0, sat_q, mode_q, 2'b00};
      else if (w == 6'd1)
         rd_d = {16'd0, ovf_q, 6'd0, done_q, busy_q};
      else if (ab_hit)
         rd_d = ab_isb ? 32'(b_q[ab_ch]) : 32'(a_q[ab_ch]);
      else if (acc_hit)
         rd_d = acc_hi ? acc_ext[63:32] : acc_ext[31:0];
   end

   // Acknowledge lasts one cycle; a held STB is re-sampled only once ACK is low.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ack_q  <= 1'b0;
         rdat_q <= '0;
      end else begin
         ack_q <= req;
         if (req && !wb_WE) rdat_q <= rd_d;
      end
   end

   // ---------------- stage 1: multiply ----------------
   logic signed [2*DW-1:0] a_ext_p0, b_ext_p0;
   assign a_ext_p0 = (2*DW)'(a_q[idx_q]);
   assign b_ext_p0 = (2*DW)'(b_q[idx_q]);

   always_ff @(posedge wb_clk_i) begin
      prod_p1 <= a_ext_p0 * b_ext_p0;
      ch_p1   <= idx_q;
   end

   // ---------------- stage 2: accumulate ----------------
   // One guard bit makes any out-of-range result visible as a mismatch
   // between the two top bits.
   function automatic logic signed [ACCW-1:0] sat_fn(input logic signed [ACCW:0] r,
                                                    input logic sat);
      logic signed [ACCW-1:0] mx, mn;
      mx = {1'b0, {(ACCW-1){1'b1}}};
      mn = {1'b1, {(ACCW-1){1'b0}}};
      if (sat && (r[ACCW] != r[ACCW-1])) return r[ACCW] ? mn : mx;
      return r[ACCW-1:0];
   endfunction

   logic signed [ACCW:0]   p_ext_p2, a_cur_p2, res_p2;
   logic signed [ACCW-1:0] acc_new_p2;
   logic                   ovf_p2;
   logic [DW-1:0]          dac_sel;

   always_comb begin
      p_ext_p2 = (ACCW+1)'(prod_p1);
      a_cur_p2 = (ACCW+1)'(acc_q[ch_p1]);
      case (mode_q)
         2'b01:   res_p2 = a_cur_p2 + p_ext_p2;
         2'b10:   res_p2 = a_cur_p2 - p_ext_p2;
         default: res_p2 = p_ext_p2;
      endcase
   end

   assign ovf_p2     = res_p2[ACCW] ^ res_p2[ACCW-1];
   assign acc_new_p2 = sat_fn(res_p2, sat_q);
   assign dac_sel    = ({1'b0, dsel_q} < 4'(CHANNELS)) ? acc_q[dsel_q][ACCW-1 -: DW] : '0;

   // ---------------- control FSM and register file ----------------
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         dcnt_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dac_q   <= '0;
         mode_q  <= '0;
         sat_q   <= 1'b0;
         dsel_q  <= '0;
         ovf_q   <= '0;
         vld_p1  <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            acc_q[i] <= '0;
         end
      end else begin
         vld_p1 <= (state_q == S_RUN);
         if (vld_p1) begin
            acc_q[ch_p1] <= acc_new_p2;
            if (ovf_p2) ovf_q[ch_p1] <= 1'b1;
         end
         // DONE clear is honoured even mid-run; a completing run sets it below.
         if (wr && (w == 6'd1) && wb_DAT_MOSI[1]) done_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (wr && (w == 6'd0)) begin
                  mode_q <= wb_DAT_MOSI[3:2];
                  sat_q  <= wb_DAT_MOSI[4];
                  dsel_q <= wb_DAT_MOSI[10:8];
                  if (wb_DAT_MOSI[1]) begin
                     ovf_q <= '0;
                     for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
                  end
                  if (wb_DAT_MOSI[0]) begin
                     state_q <= S_RUN;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end
               end else if (wr && ab_hit) begin
                  if (ab_isb) b_q[ab_ch] <= wb_DAT_MOSI[DW-1:0];
                  else        a_q[ab_ch] <= wb_DAT_MOSI[DW-1:0];
               end
            end
            S_RUN: begin
               if (idx_q == 3'(CHANNELS-1)) begin
                  state_q <= S_DRAIN;
                  dcnt_q  <= 1'b0;
               end else begin
                  idx_q <= idx_q + 3'd1;
               end
            end
            S_DRAIN: begin
               // The last channel lands in ACC during the first drain cycle,
               // so ACC[DSEL] is final when the second one ends.
               dcnt_q <= 1'b1;
               if (dcnt_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  dac_q   <= dac_sel;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wb_ACK      = ack_q;
   assign wb_DAT_MISO = rdat_q;
   assign irq_o       = done_q;
   assign busy_o      = busy_q;
   assign dac_o       = dac_q;

endmodule

// File: tb/tb_dsp_mac_wb.sv
// Testbench for dsp_mac_wb. Stimulus drives Wishbone transfers and pushes the
// expected read data into a queue. A separate monitor pops an entry on every
// ACK and compares it. Expected values come from an arithmetic model of the
// register map and the MAC rules.
module tb_dsp_mac_wb;
   localparam int CH   = 4;
   localparam int DW   = 16;
   localparam int ACCW = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]    sel = 4'h0;
   logic [31:0]   adr = '0, mosi = '0;
   logic          ack;
   logic [31:0]   miso;
   logic          irq;
   logic [DW-1:0] dac;
   logic          busy;

   always #5 clk = ~clk;

   dsp_mac_wb #(.CHANNELS(CH), .DW(DW), .ACCW(ACCW)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_CYC(cyc), .wb_STB(stb), .wb_WE(we),
      .wb_SEL(sel), .wb_ADR(adr), .wb_DAT_MOSI(mosi), .wb_ACK(ack),
      .wb_DAT_MISO(miso), .irq_o(irq), .dac_o(dac), .busy_o(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          a_m [8];
   int          b_m [8];
   longint      acc_m [8];
   bit [7:0]    ovf_m;
   bit          done_m, busy_m, sat_m;
   bit [1:0]    mode_m;
   bit [2:0]    dsel_m;
   logic [15:0] dac_m;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin a_m[i] = 0; b_m[i] = 0; acc_m[i] = 0; end
      ovf_m = '0; done_m = 0; busy_m = 0; sat_m = 0; mode_m = '0; dsel_m = '0; dac_m = '0;
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s);
      int w, c;
      w = int'(a[7:2]);
      if (s != 4'hF) return;
      if (w == 0) begin
         if (busy_m) return;
         if (d[1]) begin
            for (int i = 0; i < 8; i++) acc_m[i] = 0;
            ovf_m = '0;
         end
         mode_m = d[3:2]; sat_m = d[4]; dsel_m = d[10:8];
         if (d[0]) begin busy_m = 1; done_m = 0; end
      end else if (w == 1) begin
         if (d[1]) done_m = 0;
      end else if (w >= 4 && w < 20 && !busy_m) begin
         c = (w - 4) / 2;
         if (c < CH) begin
            if ((w - 4) % 2 == 1) b_m[c] = int'($signed(d[DW-1:0]));
            else                  a_m[c] = int'($signed(d[DW-1:0]));
         end
      end
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int w, c;
      logic [63:0] t;
      w = int'(a[7:2]);
      if (w == 0) return {21'd0, dsel_m, 3'd0, sat_m, mode_m, 2'd0};
      if (w == 1) return {16'd0, ovf_m, 6'd0, done_m, busy_m};
      if (w >= 4 && w < 20) begin
         c = (w - 4) / 2;
         if (c >= CH) return '0;
         return ((w - 4) % 2 == 1) ? b_m[c] : a_m[c];
      end
      if (w >= 32 && w < 48) begin
         c = (w - 32) / 2;
         if (c >= CH) return '0;
         t = acc_m[c];
         return (w % 2 == 1) ? t[63:32] : t[31:0];
      end
      return '0;
   endfunction

   function automatic void model_run();
      longint mx, mn, p, r;
      mx = (longint'(1) <<< (ACCW - 1)) - 1;
      mn = -(longint'(1) <<< (ACCW - 1));
      for (int c = 0; c < CH; c++) begin
         p = longint'(a_m[c]) * longint'(b_m[c]);
         if (mode_m == 2'd1)      r = acc_m[c] + p;
         else if (mode_m == 2'd2) r = acc_m[c] - p;
         else                     r = p;
         if (r > mx || r < mn) begin
            ovf_m[c] = 1'b1;
            if (sat_m) r = (r > mx) ? mx : mn;
            else       r = (r <<< (64 - ACCW)) >>> (64 - ACCW);
         end
         acc_m[c] = r;
      end
      busy_m = 0;
      done_m = 1;
      dac_m  = (int'(dsel_m) < CH) ? 16'(acc_m[dsel_m] >>> (ACCW - DW)) : 16'h0;
   endfunction

   // ---------------- scoreboard ----------------
   bit          q_chk [$];
   logic [31:0] q_exp [$];
   string       q_nm  [$];

   bit          m_chk;
   logic [31:0] m_exp;
   string       m_nm;

   always @(negedge clk) begin
      if (rst_n && ack) begin
         if (q_chk.size() == 0) begin
            check("spurious_ack", ack, 1'b0);
         end else begin
            m_chk = q_chk.pop_front();
            m_exp = q_exp.pop_front();
            m_nm  = q_nm.pop_front();
            if (m_chk) check(m_nm, miso, m_exp);
         end
      end
   end

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit chk, input logic [31:0] exp,
                       input string nm, output int lat);
      int n;
      @(posedge clk); #1;
      q_chk.push_back(chk); q_exp.push_back(exp); q_nm.push_back(nm);
      if (w) model_write(a, d, s);
      cyc = 1; stb = 1; we = w; adr = a; mosi = d; sel = s;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!ack && n < 20);
      cyc = 0; stb = 0; we = 0;
      lat = n;
      if (!ack) begin
         void'(q_chk.pop_back()); void'(q_exp.pop_back()); void'(q_nm.pop_back());
         check("ack_timeout", ack, 1'b1);
      end
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      int lat;
      xfer(1'b1, a, d, 4'hF, 1'b0, '0, "wr", lat);
   endtask

   task automatic wr_sel(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int lat;
      xfer(1'b1, a, d, s, 1'b0, '0, "wr_sel", lat);
   endtask

   task automatic rd(input logic [31:0] a, input string nm);
      int lat;
      xfer(1'b0, a, '0, 4'hF, 1'b1, model_read(a), nm, lat);
   endtask

   task automatic rd_exp(input logic [31:0] a, input logic [31:0] e, input string nm);
      int lat;
      xfer(1'b0, a, '0, 4'hF, 1'b1, e, nm, lat);
   endtask

   task automatic rd_all(input string nm);
      rd(32'h0, {nm, "_ctrl"});
      rd(32'h4, {nm, "_status"});
      for (int c = 0; c < CH; c++) begin
         rd(32'h10 + 8*c, {nm, "_a"});
         rd(32'h14 + 8*c, {nm, "_b"});
         rd(32'h80 + 8*c, {nm, "_acc_lo"});
         rd(32'h84 + 8*c, {nm, "_acc_hi"});
      end
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy && cnt < 50) begin cnt++; @(posedge clk); #1; end
      check("run_end", busy, 1'b0);
   endtask

   task automatic do_run(input logic [31:0] ctrl);
      int cnt;
      wr_reg(32'h0, ctrl | 32'h1);
      wait_idle(cnt);
      model_run();
      check("busy_cycles", cnt, CH + 2);
      check("irq_done", irq, 1'b1);
      check("dac", dac, dac_m);
   endtask

   task automatic set_ab(input int c, input int av, input int bv);
      wr_reg(32'h10 + 8*c, 32'(av));
      wr_reg(32'h14 + 8*c, 32'(bv));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      int lat, cnt, n;
      logic [31:0] d;
      int a0 [4] = '{3, -2, 100, -32768};
      int b0 [4] = '{4, 5, -7, -32768};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", ack, 1'b0);
      check("rst_miso", miso, 32'h0);
      check("rst_irq", irq, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_dac", dac, 16'h0);
      rst_n = 1'b1;

      // every word address reads back zero after reset
      for (int w = 0; w < 64; w++) rd(32'(w * 4), "reset_rd");
      xfer(1'b0, 32'hFC, '0, 4'hF, 1'b1, 32'h0, "rd_fc", lat);
      check("fc_ack_latency", lat, 1);

      // plain multiply
      for (int c = 0; c < CH; c++) set_ab(c, a0[c], b0[c]);
      do_run(32'h0);
      rd_all("mul");
      rd_exp(32'h98, 32'h40000000, "mul_acc3_const");

      // three MAC runs from a cleared accumulator, then clear DONE
      wr_reg(32'h0, 32'h6);
      set_ab(0, 1000, 1000);
      repeat (3) do_run(32'h4);
      rd_exp(32'h80, 32'd3000000, "mac_acc0_const");
      rd_all("mac");
      wr_reg(32'h4, 32'h2);
      check("irq_cleared", irq, 1'b0);
      rd(32'h4, "status_after_clear");

      // saturating MAC until channel 0 overflows
      wr_reg(32'h0, 32'h16);
      set_ab(0, -32768, -32768);
      n = 0;
      while (!ovf_m[0] && n < 600) begin do_run(32'h14); n++; end
      rd_exp(32'h84, 32'h0000007F, "sat_hi_const");
      rd_exp(32'h80, 32'hFFFFFFFF, "sat_lo_const");
      rd_all("sat");

      // wrapping MAC until channel 0 overflows
      wr_reg(32'h0, 32'h6);
      n = 0;
      while (!ovf_m[0] && n < 600) begin do_run(32'h4); n++; end
      rd_exp(32'h84, 32'hFFFFFF80, "wrap_hi_const");
      rd_exp(32'h80, 32'h00000000, "wrap_lo_const");
      rd_all("wrap");

      // build ACC1 = 0x12_3456_0000 and route it to the DAC
      wr_reg(32'h0, 32'h2);
      set_ab(1, -32768, -26796);
      do_run(32'h100);
      wr_reg(32'h1C, 32'hFFFF8000);
      repeat (72) do_run(32'h104);
      check("dac_1234", dac, 16'h1234);
      rd_all("dsel");

      // writes while busy are dropped but still acked
      wr_reg(32'h0, 32'h105);
      wr_reg(32'h10, 32'h7777);
      wr_reg(32'h0, 32'h3);
      wait_idle(cnt);
      model_run();
      check("busy_irq", irq, 1'b1);
      check("busy_dac", dac, dac_m);
      @(posedge clk); #1;
      check("no_restart", busy, 1'b0);
      rd(32'h10, "a0_unchanged");
      rd_all("busywr");

      // STATUS read while running shows BUSY
      wr_reg(32'h0, 32'h105);
      rd(32'h4, "status_busy");
      wait_idle(cnt);
      model_run();
      rd(32'h4, "status_done");

      // reset two cycles into a run
      wr_reg(32'h0, 32'h5);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("midrst_busy", busy, 1'b0);
      check("midrst_irq", irq, 1'b0);
      check("midrst_dac", dac, 16'h0);
      check("midrst_ack", ack, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd_all("after_rst");
      for (int c = 0; c < CH; c++) set_ab(c, a0[c], b0[c]);
      do_run(32'h0);
      rd_all("fresh");

      // randomized runs
      for (int it = 0; it < 25; it++) begin
         for (int c = 0; c < CH; c++) begin
            wr_reg(32'h10 + 8*c, $urandom);
            wr_reg(32'h14 + 8*c, $urandom);
         end
         wr_sel(32'h10 + 8*$urandom_range(0, CH-1), $urandom, 4'($urandom_range(0, 14)));
         d = 32'($urandom_range(1, 63)) << 2;
         wr_reg(d, $urandom);
         rd(d, "rand_addr");
         d = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 1)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 1);
         do_run(d);
         rd_all("rand");
      end

      repeat (5) @(posedge clk);
      check("scoreboard_empty", 64'(q_chk.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_mac_wb.md
# dsp_mac_wb

Wishbone-attached, parametrised multiply-accumulate engine: the next generation of the single DSP48 slice behind the user project wrapper. It holds CHANNELS signed operand pairs and accumulators and runs them through one shared 2-stage pipelined multiplier on a START command. Modes are multiply, multiply-accumulate and multiply-subtract, with optional saturation. The management SoC drives it over Wishbone; a completion interrupt goes to user_irq and a registered DAC word goes to the IO pads.

## Interface
- CHANNELS, 4: number of operand/accumulator channels, 1..8
- DW, 16: signed operand width, 2..32
- ACCW, 40: signed accumulator width, 2*DW..64, and at least 33
- wb_clk_i  in  1  single clock, all logic rising-edge
- wb_rst_n_i  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- wb_CYC, wb_STB, wb_WE  in  1 each  Wishbone classic slave controls
- wb_SEL  in  4  byte enables; any register write requires wb_SEL == 4'hF, otherwise the write is acked and dropped
- wb_ADR  in  32  byte address; bits [7:2] decoded, upper bits ignored
- wb_DAT_MOSI  in  32  write data
- wb_ACK  out  1  transfer acknowledge
- wb_DAT_MISO  out  32  read data
- irq_o  out  1  level, equals STATUS.DONE
- dac_o  out  DW  top DW bits of the selected accumulator, registered
- busy_o  out  1  engine running

## Operation
- Register map (byte offsets):
  - 0x00 CTRL, R/W.
    - bit0 START: write-1 starts a run; self-clearing, reads 0.
    - bit1 CLR: write-1 zeroes all accumulators and OVF; self-clearing.
    - bits[3:2] MODE: 00 MUL (acc=a*b), 01 MAC (acc+=a*b), 10 MSUB (acc-=a*b), 11 treated as MUL.
    - bit4 SAT.
    - bits[10:8] DSEL, the DAC channel select.
  - 0x04 STATUS.
    - bit0 BUSY: read-only.
    - bit1 DONE: sticky; write-1 clears it.
    - bits[15:8] OVF[c]: sticky per channel; cleared by CLR only.
  - 0x10+8c A_c and 0x14+8c B_c: low DW bits are stored; reads return them sign-extended.
  - 0x80+8c ACC_c[31:0] and 0x84+8c ACC_c[ACCW-1:32]: read-only; the high word reads sign-extended.
  - Unmapped addresses, or channel c ≥ CHANNELS: reads return 0, writes are ignored, the access is still acked.
- FSM IDLE → RUN → DRAIN → IDLE.
  - IDLE: a START write loads idx=0, sets BUSY and clears DONE.
  - RUN: issues channel idx to stage 1 (P = A*B, 2*DW bits) and increments idx each cycle. After idx = CHANNELS-1 the FSM goes to DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, then returns to IDLE. On that transition: BUSY=0, DONE=1, dac_o updated from ACC[DSEL].
- Stage 2 sign-extends P to ACCW+1 bits and computes the mode result. Overflow is when the result is outside the ACCW signed range.
  - On overflow, OVF[c] is set.
  - SAT=1: the stored value clamps to +2^(ACCW-1)-1 or -2^(ACCW-1).
  - SAT=0: the low ACCW bits wrap.
- Writes while BUSY: CTRL, A and B writes are acked and dropped, including START and CLR. STATUS DONE write-1 is honoured. All reads are allowed.
- CLR and START in the same write: CLR applies first, then the run starts from zero.
- DSEL ≥ CHANNELS: dac_o is loaded with 0.

## Timing
- Reset values:
  - wb_ACK=0, wb_DAT_MISO=0, irq_o=0, busy_o=0, dac_o=0.
  - All A, B, ACC, CTRL and STATUS bits are 0; the FSM is in IDLE.
- Wishbone: wb_ACK rises the cycle after CYC&STB are seen with ACK low. It stays high for exactly one cycle and drops even if STB stays high. The next ack needs STB to be re-sampled with ACK low. Read data is valid with ACK.
- Write effects: register writes take effect on the ACK edge. A START write asserts BUSY on that same edge.
- Run length: BUSY is high for exactly CHANNELS+2 cycles. DONE, irq_o and dac_o update on the edge where BUSY falls.
- ACC_c visibility: ACC_c updates 2 cycles after channel c is issued, and reads show it from the following cycle.
- Reset mid-run: asserting wb_rst_n_i aborts immediately. All state returns to reset values; a pending ACK is dropped.

## Test plan
- Reset, then read every mapped register → all 0. Read 0xFC → 0 with ACK one cycle later.
- CHANNELS=4, MODE=MUL: A={3,-2,100,-32768}, B={4,5,-7,-32768} → ACC={12,-10,-700,1073741824}. BUSY lasts exactly 6 cycles; DONE=1, irq_o=1, OVF=0.
- MODE=MAC, A0=1000, B0=1000, START three times → ACC0=3000000. STATUS write 0x2 → DONE=0, irq_o low next cycle.
- ACCW=40, SAT=1, MODE=MAC, A0=B0=-32768, repeated START until overflow → ACC0 clamps at 0x7F_FFFF_FFFF and OVF[0]=1. The same with SAT=0 → ACC0 wraps negative and OVF[0]=1.
- Write A0 while BUSY → A0 unchanged and ACK still given. DSEL=1 with ACC1=0x12_3456_0000 → dac_o=0x1234 after DONE.
- Assert reset 2 cycles into RUN → BUSY=0, ACC=0, no irq. A fresh START then completes normally.
